reg_sequencer: RTL and testbench

REG_SEQUENCER -- requirements
Module: reg_sequencer

---
 rtl/reg_sequencer.sv | 136 +++++++++++++
 tb/tb_reg_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/reg_sequencer.sv
// Register-transfer sequencer: turns one command into per-cycle function codes for registers X, Y and Z.
// Optional feature: define SEQ_MULTISHIFT_EN so SHRZ/SHLZ repeat count+1 cycles instead of a single cycle.
module reg_sequencer #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  output logic [2:0]       tx,
  output logic [2:0]       ty,
  output logic [2:0]       tz,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] FN_HOLD   = 3'b000;
  localparam logic [2:0] FN_LOAD   = 3'b001;
  localparam logic [2:0] FN_SHIFTR = 3'b010;
  localparam logic [2:0] FN_SHIFTL = 3'b011;
  localparam logic [2:0] FN_RESET  = 3'b100;

  localparam logic [2:0] OP_LDX  = 3'b001;
  localparam logic [2:0] OP_MOVE = 3'b010;
  localparam logic [2:0] OP_SHRZ = 3'b011;
  localparam logic [2:0] OP_SHLZ = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;

  localparam logic [CNT_W:0] STEP_ZERO = '0;
  localparam logic [CNT_W:0] STEP_ONE  = {{CNT_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state, state_next;
  logic [2:0]     op_q, op_next;
  logic [CNT_W:0] step, step_next;
  logic [CNT_W:0] last_step;

`ifdef SEQ_MULTISHIFT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset)
      count_q <= '0;
    else if (state == IDLE && start)
      count_q <= count;
  end

  // Shift commands end after count+1 steps; the extra counter bit keeps max count from wrapping.
  always_comb begin
    last_step = STEP_ZERO;
    case (op_q)
      OP_MOVE:          last_step = STEP_ONE;
      OP_SHRZ, OP_SHLZ: last_step = {1'b0, count_q};
      default:          last_step = STEP_ZERO;
    endcase
  end
`else
  logic unused_count;
  assign unused_count = ^count;

  always_comb begin
    last_step = STEP_ZERO;
    if (op_q == OP_MOVE)
      last_step = STEP_ONE;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= 3'b000;
      step  <= STEP_ZERO;
    end else begin
      state <= state_next;
      op_q  <= op_next;
      step  <= step_next;
    end
  end

  always_comb begin
    state_next = state;
    op_next    = op_q;
    step_next  = step;
    case (state)
      IDLE: begin
        if (start) begin
          op_next    = op;
          step_next  = STEP_ZERO;
          state_next = (op >= OP_LDX && op <= OP_CLR) ? EXEC : DONE;
        end
      end
      EXEC: begin
        if (step == last_step)
          state_next = DONE;
        else
          step_next = step + 1'b1;
      end
      DONE: begin
        state_next = IDLE;
        step_next  = STEP_ZERO;
      end
      default: state_next = IDLE;
    endcase
  end

  // Codes are a pure decode of state, latched op and step, so they never glitch on start.
  always_comb begin
    tx   = FN_HOLD;
    ty   = FN_HOLD;
    tz   = FN_HOLD;
    busy = (state != IDLE);
    done = (state == DONE);
    if (state == EXEC) begin
      case (op_q)
        OP_LDX: tx = FN_LOAD;
        OP_MOVE: begin
          if (step == STEP_ZERO)
            tz = FN_LOAD;
          else
            ty = FN_LOAD;
        end
        OP_SHRZ: tz = FN_SHIFTR;
        OP_SHLZ: tz = FN_SHIFTL;
        OP_CLR: begin
          tx = FN_RESET;
          ty = FN_RESET;
          tz = FN_RESET;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_sequencer.sv
// Self-checking bench for reg_sequencer: a queue of expected per-cycle output vectors predicts the DUT.
// Honours SEQ_MULTISHIFT_EN the same way the design does when predicting shift lengths.
module tb_reg_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op    = 3'b000;
  logic [1:0] count = 2'b00;
  logic [2:0] tx, ty, tz;
  logic       busy, done;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Each entry is {tx, ty, tz, busy, done} for one upcoming cycle; empty means idle.
  logic [10:0] exp_q[$];

  reg_sequencer #(.CNT_W(2)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .count(count),
    .tx(tx), .ty(ty), .tz(tz), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [10:0] vec(input logic [2:0] x, input logic [2:0] y,
                                      input logic [2:0] z, input logic b, input logic d);
    return {x, y, z, b, d};
  endfunction

  task automatic push_cmd(input logic [2:0] o, input logic [1:0] c);
    int n;
    case (o)
      3'd1: exp_q.push_back(vec(3'd1, 3'd0, 3'd0, 1'b1, 1'b0));
      3'd2: begin
        exp_q.push_back(vec(3'd0, 3'd0, 3'd1, 1'b1, 1'b0));
        exp_q.push_back(vec(3'd0, 3'd1, 3'd0, 1'b1, 1'b0));
      end
      3'd3, 3'd4: begin
`ifdef SEQ_MULTISHIFT_EN
        n = int'(c) + 1;
`else
        n = 1;
`endif
        for (int i = 0; i < n; i++)
          exp_q.push_back(vec(3'd0, 3'd0, (o == 3'd3) ? 3'd2 : 3'd3, 1'b1, 1'b0));
      end
      3'd5: exp_q.push_back(vec(3'd4, 3'd4, 3'd4, 1'b1, 1'b0));
      default: ;
    endcase
    exp_q.push_back(vec(3'd0, 3'd0, 3'd0, 1'b1, 1'b1));
  endtask

  // Check the current cycle at the falling edge, then drive inputs for the next rising edge.
  task automatic apply_stimulus(input logic s, input logic [2:0] o, input logic [1:0] c,
                                input logic r, input string tag);
    logic [10:0] exp_v, obs;
    @(negedge clock);
    cyc++;
    exp_v = (exp_q.size() != 0) ? exp_q[0] : 11'b0;
    obs   = {tx, ty, tz, busy, done};
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("[TB] FAIL %s cycle %0d: observed tx/ty/tz/busy/done=%b expected %b", tag, cyc, obs, exp_v);
    end
    start = s;
    op    = o;
    count = c;
    reset = r;
    if (r)
      exp_q.delete();
    else if (exp_q.size() != 0)
      void'(exp_q.pop_front());
    else if (s)
      push_cmd(o, c);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++)
      apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, tag);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: observed %0d pending cycles expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, {tag, "_idle"});
  endtask

  task automatic run_cmd(input logic [2:0] o, input logic [1:0] c, input string tag);
    apply_stimulus(1'b1, o, c, 1'b0, tag);
    drain(tag);
  endtask

  initial begin
    logic       s, r;
    logic [2:0] o;
    logic [1:0] c;

    repeat (2) @(posedge clock);
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b1, "reset");
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, "reset_idle");

    run_cmd(3'd1, 2'd0, "ldx");
    run_cmd(3'd2, 2'd0, "move");
    run_cmd(3'd3, 2'd3, "shrz_c3");
    run_cmd(3'd4, 2'd0, "shlz_c0");
    run_cmd(3'd5, 2'd1, "clr");
    run_cmd(3'd7, 2'd2, "op111");
    run_cmd(3'd6, 2'd1, "op110");
    run_cmd(3'd0, 2'd3, "nop");

    // A CLR request during an SHLZ must be dropped, not queued.
    apply_stimulus(1'b1, 3'd4, 2'd2, 1'b0, "busy_ignore");
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, "busy_ignore");
    apply_stimulus(1'b1, 3'd5, 2'd0, 1'b0, "busy_ignore");
    drain("busy_ignore");

    // Reset during the second shift step aborts with no done pulse.
    apply_stimulus(1'b1, 3'd4, 2'd3, 1'b0, "abort");
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, "abort");
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b1, "abort");
    repeat (3) apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, "abort_after");

    // start held through DONE is ignored; the next accept needs an IDLE cycle.
    apply_stimulus(1'b1, 3'd1, 2'd0, 1'b0, "done_start");
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, "done_start");
    apply_stimulus(1'b1, 3'd5, 2'd0, 1'b0, "done_start");
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, "done_start");
    drain("done_start");

    // Reset wins over a simultaneous start.
    apply_stimulus(1'b1, 3'd1, 2'd0, 1'b1, "reset_prio");
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, "reset_prio");
    apply_stimulus(1'b0, 3'd0, 2'd0, 1'b0, "reset_prio");

    for (int i = 0; i < 500; i++) begin
      s = ($urandom_range(0, 2) == 0);
      o = 3'($urandom_range(0, 7));
      c = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 39) == 0);
      apply_stimulus(s, o, c, r, "random");
    end
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
